uart_mmio_tx: RTL and testbench

Memory-mapped UART transmitter that consumes the memory stage's MMIO write strobe and data. It sits directly downstream of the core's memory stage. Each MMIO write queues one byte into a small FIFO, and a baud-timed state machine serialises the bytes on `tx` as 8N1 frames (8E1 when parity is compiled in). A ready/status output lets the core poll for space before writing.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_mmio_tx_if.sv | 20 ++
 rtl/uart_tx_fifo.sv | 42 ++++
 rtl/uart_mmio_tx.sv | 106 ++++++++++
 tb/tb_uart_mmio_tx.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the MMIO UART transmitter.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam logic        UART_IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

endpackage

// File: rtl/uart_mmio_tx_if.sv
// Core-side MMIO write and status bundle for the UART transmitter.
interface uart_mmio_tx_if;

    logic        mmio_wea;
    logic [31:0] mmio_dat;
    logic        mmio_ready;
    logic        tx_busy;
    logic        tx_overflow;

    modport master (
        output mmio_wea, mmio_dat,
        input  mmio_ready, tx_busy, tx_overflow
    );

    modport slave (
        input  mmio_wea, mmio_dat,
        output mmio_ready, tx_busy, tx_overflow
    );

endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a push to a full FIFO is dropped even with a same-cycle pop.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             Rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wr_q;
    logic [PW-1:0]    rd_q;
    logic [WIDTH-1:0] mem [DEPTH];

    // Same index with differing wrap bits means the writer has lapped the reader.
    assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty    = (wr_q == rd_q);
    assign pop_data = mem[rd_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (Rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push && !full) wr_q <= wr_q + PW'(1);
            if (pop && !empty) rd_q <= rd_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_mmio_tx.sv
// MMIO-fed UART transmitter: byte FIFO plus baud-timed 8N1 serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
module uart_mmio_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic             clk,
    input  logic             Rst,
    uart_mmio_tx_if.slave    bus,
    output logic             tx
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BW = $clog2(UART_DATA_BITS);

    tx_state_t                 state_q, state_d;
    logic [CW-1:0]             baud_q, baud_d;
    logic [BW-1:0]             bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] data_q, data_d;
    logic                      tx_q, tx_d;
    logic                      ovf_q;

    logic                      full, empty, pop_c;
    logic [UART_DATA_BITS-1:0] head;
    logic                      baud_done, last_bit;

    wire unused_hi = ^bus.mmio_dat[31:UART_DATA_BITS];

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk       (clk),
        .Rst       (Rst),
        .push      (bus.mmio_wea),
        .push_data (bus.mmio_dat[UART_DATA_BITS-1:0]),
        .pop       (pop_c),
        .pop_data  (head),
        .full      (full),
        .empty     (empty)
    );

    assign baud_done = (baud_q == CW'(CLKS_PER_BIT - 1));
    assign last_bit  = (bit_q == BW'(UART_DATA_BITS - 1));

    assign tx              = tx_q;
    assign bus.mmio_ready  = !full;
    assign bus.tx_busy     = (state_q != IDLE) || !empty;
    assign bus.tx_overflow = ovf_q;

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (Rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            tx_q    <= UART_IDLE_LEVEL;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
            if (bus.mmio_wea && full) ovf_q <= 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (!empty) state_d = START;
            START:  if (baud_done) state_d = DATA;
`ifdef UART_TX_PARITY_EN
            DATA:   if (baud_done && last_bit) state_d = PARITY;
`else
            DATA:   if (baud_done && last_bit) state_d = STOP;
`endif
            PARITY: if (baud_done) state_d = STOP;
            STOP:   if (baud_done) state_d = empty ? IDLE : START;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: pop on entry to START, line level follows the next state
    always_comb begin
        pop_c  = (state_d == START) && (state_q != START);
        baud_d = (baud_done || state_q == IDLE) ? '0 : baud_q + CW'(1);
        bit_d  = bit_q;
        data_d = data_q;
        tx_d   = UART_IDLE_LEVEL;
        if (state_q == DATA && baud_done) bit_d = bit_q + BW'(1);
        if (pop_c) data_d = head;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_d[bit_d];
            PARITY:  tx_d = ^data_q;
            default: tx_d = UART_IDLE_LEVEL;
        endcase
    end

endmodule

// File: tb/tb_uart_mmio_tx.sv
// Scoreboard bench for uart_mmio_tx: cycle-level frame model plus a serial-line decoder.
module tb_uart_mmio_tx;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 16;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned NB = 11;
`else
    localparam int unsigned NB = 10;
`endif
    localparam int unsigned FRAME = NB * CPB;

    logic clk = 1'b0;
    logic Rst = 1'b1;
    logic tx;

    uart_mmio_tx_if bus ();

    uart_mmio_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk (clk),
        .Rst (Rst),
        .bus (bus),
        .tx  (tx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: bytes waiting, and how many cycles of the current frame remain
    logic [7:0]    mq[$];
    logic [7:0]    exp_q[$];
    int            frame_left = 0;
    bit            m_ovf = 1'b0;
    int            rst_events = 0;
    logic [NB-1:0] fbits = '1;

    function automatic logic [NB-1:0] frame_of(input logic [7:0] b);
        logic [NB-1:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = b;
`ifdef UART_TX_PARITY_EN
        f[9]   = ^b;
`endif
        return f;
    endfunction

    initial begin : model
        bit full_pre;
        int sz_pre;
        forever begin
            @(posedge clk);
            if (Rst) begin
                mq.delete();
                exp_q.delete();
                frame_left = 0;
                m_ovf = 1'b0;
                rst_events++;
            end else begin
                full_pre = (mq.size() == DEPTH);
                sz_pre   = mq.size();
                if (frame_left > 0) frame_left--;
                if (frame_left == 0 && sz_pre > 0) begin
                    fbits = frame_of(mq.pop_front());
                    frame_left = FRAME;
                end
                if (bus.mmio_wea) begin
                    if (full_pre) m_ovf = 1'b1;
                    else begin
                        mq.push_back(bus.mmio_dat[7:0]);
                        exp_q.push_back(bus.mmio_dat[7:0]);
                    end
                end
            end
        end
    end

    // Per-cycle comparison of line level and status against the model
    initial begin : cycle_checker
        logic tx_exp;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                tx_exp = (frame_left > 0) ? fbits[(FRAME - frame_left) / CPB] : 1'b1;
                check("tx_level", tx, tx_exp);
                check("mmio_ready", bus.mmio_ready, mq.size() < DEPTH);
                check("tx_busy", bus.tx_busy, (frame_left > 0) || (mq.size() > 0));
                check("tx_overflow", bus.tx_overflow, m_ovf);
            end
        end
    end

    // Serial decoder: samples mid-bit and pops the scoreboard at the end of each frame
    int         frames_rx = 0;
    logic [7:0] last_rx = '0;

    initial begin : decoder
        bit            active = 1'b0;
        int            cyc = 0;
        int            seen_rst = 0;
        logic [NB-1:0] bits = '1;
        logic [7:0]    want;
        forever begin
            @(negedge clk);
            if (!chk_en) continue;
            if (seen_rst != rst_events) begin
                seen_rst = rst_events;
                active = 1'b0;
            end
            if (!active) begin
                if (tx === 1'b0) begin
                    active = 1'b1;
                    cyc = 0;
                end
            end else cyc++;
            if (active && (cyc % CPB) == CPB / 2) begin
                bits[cyc / CPB] = tx;
                if (cyc / CPB == NB - 1) begin
                    active = 1'b0;
                    frames_rx++;
                    last_rx = bits[8:1];
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_unexpected_frame: got byte %0h expected none at %0t", bits[8:1], $time);
                    end else begin
                        want = exp_q.pop_front();
                        check("rx_byte", bits[8:1], want);
                        check("start_bit", bits[0], 1'b0);
                        check("stop_bit", bits[NB-1], 1'b1);
`ifdef UART_TX_PARITY_EN
                        check("parity_bit", bits[9], ^want);
`endif
                    end
                end
            end
        end
    end

    task automatic drive(input bit we, input logic [31:0] d);
        @(posedge clk);
        #1;
        bus.mmio_wea = we;
        bus.mmio_dat = d;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        drive(1'b0, 32'h0);
        while ((frame_left > 0 || mq.size() > 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check(name, n < budget, 1'b1);
        check({name, "_sb_empty"}, exp_q.size(), 0);
    endtask

    initial begin : stimulus
        int f0;
        int n;
        int rate;
        bus.mmio_wea = 1'b0;
        bus.mmio_dat = '0;
        Rst = 1'b1;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        Rst = 1'b0;

        @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_ready", bus.mmio_ready, 1'b1);
        check("rst_busy", bus.tx_busy, 1'b0);
        check("rst_ovf", bus.tx_overflow, 1'b0);

        f0 = frames_rx;
        drive(1'b1, 32'h55);
        wait_idle(3 * FRAME, "idle_55");
        check("frames_55", frames_rx - f0, 1);
        check("dec_55", last_rx, 8'h55);

        f0 = frames_rx;
        drive(1'b1, 32'hA3);
        drive(1'b1, 32'h0F);
        wait_idle(4 * FRAME, "idle_a3_0f");
        check("frames_a3_0f", frames_rx - f0, 2);
        check("dec_0f", last_rx, 8'h0F);

        drive(1'b1, 32'hDEADBE41);
        wait_idle(3 * FRAME, "idle_41");
        check("dec_41", last_rx, 8'h41);

        f0 = frames_rx;
        for (int i = 0; i < 18; i++) drive(1'b1, 32'(i));
        drive(1'b0, 32'h0);
        @(negedge clk);
        check("burst_ovf", bus.tx_overflow, 1'b1);
        check("burst_ready", bus.mmio_ready, 1'b0);
        wait_idle(20 * FRAME, "idle_burst");
        check("burst_frames", frames_rx - f0, 17);
        check("burst_last", last_rx, 8'h10);

        drive(1'b1, 32'hFF);
        drive(1'b0, 32'h0);
        n = 0;
        while (!(frame_left > 0 && (FRAME - frame_left) / CPB == 4) && n < 4 * FRAME) begin
            @(negedge clk);
            n++;
        end
        check("reach_bit3", n < 4 * FRAME, 1'b1);
        f0 = frames_rx;
        Rst = 1'b1;
        @(posedge clk);
        #1;
        Rst = 1'b0;
        @(negedge clk);
        check("rst_mid_tx", tx, 1'b1);
        check("rst_mid_busy", bus.tx_busy, 1'b0);
        check("rst_mid_ovf", bus.tx_overflow, 1'b0);
        repeat (3 * FRAME) drive(1'b0, 32'h0);
        check("rst_no_frame", frames_rx - f0, 0);

        for (int ph = 0; ph < 3; ph++) begin
            rate = (ph == 1) ? 40 : 3;
            for (int i = 0; i < 600; i++)
                drive(($urandom_range(0, 99) < rate), $urandom);
            wait_idle((DEPTH + 3) * FRAME, "idle_random");
        end

        f0 = frames_rx;
        drive(1'b1, 32'h07);
        wait_idle(3 * FRAME, "idle_07");
        check("dec_07", last_rx, 8'h07);
        drive(1'b1, 32'h03);
        wait_idle(3 * FRAME, "idle_03");
        check("dec_03", last_rx, 8'h03);
        check("frames_parity", frames_rx - f0, 2);

        check("final_sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
